// File: rtl/ccff_chain_loader_pkg.sv
// Shared FSM encoding and CRC constants for the configuration-chain loader.
package ccff_chain_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;

endpackage

// File: rtl/ccff_chain_loader_crc8.sv
// Serial bit-in CRC-8 (init 0x00), one bit per enabled clock, synchronous clear.
module ccff_crc8
  import ccff_chain_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q;
  logic       fb;

  assign fb    = crc_q[7] ^ bit_i;
  assign crc_o = crc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     crc_q <= 8'h00;
    else if (clr_i) crc_q <= 8'h00;
    else if (en_i)  crc_q <= {crc_q[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises bitstream words MSB-first onto a ccff chain for exactly CHAIN_LEN bits.
// Optional CRC-8 trailer check is built when CCFF_CRC_EN is defined.
module ccff_chain_loader
  import ccff_chain_loader_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              prog_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int              BL_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN);

  state_e            state_q;
  logic [WORD_W-1:0] word_q;
  logic [BL_W-1:0]   bits_left_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic              word_ready_q, ccff_head_q, prog_clk_en_q, busy_q, done_q, err_q;

  logic accept, emit_bit;

  assign accept   = word_valid && word_ready_q;
  // Bit launched onto the chain at the coming edge: fresh word MSB or next held bit.
  assign emit_bit = (state_q == ST_LOAD) ? word_in[WORD_W-1] : word_q[WORD_W-1];

  assign word_ready  = word_ready_q;
  assign ccff_head   = ccff_head_q;
  assign prog_clk_en = prog_clk_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

`ifdef CCFF_CRC_EN
  logic       start_acc, emit;
  logic [7:0] crc_head, crc_tail;
  logic [7:0] unused_crc_tail;

  assign start_acc = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign emit      = (state_q == ST_LOAD && accept) ||
                     (state_q == ST_SHIFT && bit_cnt_q != LAST && bits_left_q != '0);

  ccff_crc8 u_crc_head (
    .clk(prog_clk), .rst_n(pReset_n), .clr_i(start_acc),
    .en_i(emit), .bit_i(emit_bit), .crc_o(crc_head)
  );

  // Tail readback CRC reflects the chain's previous contents; debug visibility only.
  ccff_crc8 u_crc_tail (
    .clk(prog_clk), .rst_n(pReset_n), .clr_i(start_acc),
    .en_i(prog_clk_en_q), .bit_i(ccff_tail), .crc_o(crc_tail)
  );
  assign unused_crc_tail = crc_tail;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q       <= ST_IDLE;
      word_q        <= '0;
      bits_left_q   <= '0;
      bit_cnt_q     <= '0;
      word_ready_q  <= 1'b0;
      ccff_head_q   <= 1'b0;
      prog_clk_en_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q      <= ST_LOAD;
            word_ready_q <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            bit_cnt_q    <= '0;
          end
        end
        ST_LOAD: begin
          // Accept edge also launches the first bit so a word costs WORD_W+1 cycles.
          if (accept) begin
            state_q       <= ST_SHIFT;
            word_ready_q  <= 1'b0;
            word_q        <= word_in << 1;
            bits_left_q   <= BL_W'(WORD_W - 1);
            bit_cnt_q     <= bit_cnt_q + CNT_W'(1);
            ccff_head_q   <= emit_bit;
            prog_clk_en_q <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (bit_cnt_q == LAST) begin
            prog_clk_en_q <= 1'b0;
`ifdef CCFF_CRC_EN
            state_q       <= ST_CHECK;
            word_ready_q  <= 1'b1;
`else
            state_q       <= ST_DONE;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
`endif
          end else if (bits_left_q == '0) begin
            prog_clk_en_q <= 1'b0;
            state_q       <= ST_LOAD;
            word_ready_q  <= 1'b1;
          end else begin
            ccff_head_q   <= emit_bit;
            word_q        <= word_q << 1;
            bits_left_q   <= bits_left_q - BL_W'(1);
            bit_cnt_q     <= bit_cnt_q + CNT_W'(1);
          end
        end
`ifdef CCFF_CRC_EN
        ST_CHECK: begin
          if (accept) begin
            state_q      <= ST_DONE;
            word_ready_q <= 1'b0;
            err_q        <= (word_in[7:0] != crc_head);
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomised self-checking bench: two loader instances (CHAIN_LEN 4 and 10) against a bit-list model.
module tb_ccff_chain_loader;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       sel = 1'b0, start_c = 1'b0, valid_c = 1'b0, tail_c = 1'b0;
  logic [7:0] word_c = 8'h00;

  logic s4, v4, r4, h4, e4, b4, d4, x4;
  logic s10, v10, r10, h10, e10, b10, d10, x10;
  logic ready_o, head_o, en_o, busy_o, done_o, err_o;

  always #5 clk = ~clk;

  assign s4  = !sel && start_c;
  assign v4  = !sel && valid_c;
  assign s10 = sel && start_c;
  assign v10 = sel && valid_c;

  assign ready_o = sel ? r10 : r4;
  assign head_o  = sel ? h10 : h4;
  assign en_o    = sel ? e10 : e4;
  assign busy_o  = sel ? b10 : b4;
  assign done_o  = sel ? d10 : d4;
  assign err_o   = sel ? x10 : x4;

  ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(4), .CNT_W(16)) dut4 (
    .prog_clk(clk), .pReset_n(rst_n), .start(s4), .word_in(word_c), .word_valid(v4),
    .word_ready(r4), .ccff_head(h4), .prog_clk_en(e4), .ccff_tail(tail_c),
    .busy(b4), .done(d4), .err(x4));

  ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(10), .CNT_W(16)) dut10 (
    .prog_clk(clk), .pReset_n(rst_n), .start(s10), .word_in(word_c), .word_valid(v10),
    .word_ready(r10), .ccff_head(h10), .prog_clk_en(e10), .ccff_tail(tail_c),
    .busy(b10), .done(d10), .err(x10));

  int         errors = 0, checks = 0, cyc = 0;
  logic [7:0] wq[$];
  bit         got[$];

  function automatic int clen();
    return sel ? 10 : 4;
  endfunction

  // Expected chain bit i: words concatenated MSB-first.
  function automatic bit exp_bit(input int i);
    logic [7:0] w;
    w = wq[i / 8];
    return w[7 - (i % 8)];
  endfunction

  // CRC-8 as remainder of (message * x^8) mod (x^8 + x^2 + x + 1).
  function automatic logic [7:0] crc_model(input int n);
    logic [8:0] r;
    r = '0;
    for (int i = 0; i < n + 8; i++) begin
      r = {r[7:0], (i < n) ? exp_bit(i) : 1'b0};
      if (r[8]) r = r ^ 9'h107;
    end
    return r[7:0];
  endfunction

  task automatic run_load(input string name, input int first_idle, input int idle_max,
                          input bit poke, input bit bad_crc);
    int         n, wi, idle;
    bit         ovl, tmo;
    logic [7:0] crc_e;
    logic [15:0] gv, ev;
    logic       exp_err;
    n = clen(); wi = 0; idle = first_idle; ovl = 0; tmo = 0;
    crc_e = crc_model(n);
    exp_err = 1'b0;
`ifdef CCFF_CRC_EN
    wq.push_back(bad_crc ? 8'h00 : crc_e);
    exp_err = bad_crc && (crc_e != 8'h00);
`endif
    got.delete();
    @(negedge clk); start_c = 1'b1; cyc = 0;
    forever begin
      @(negedge clk); cyc++;
      start_c = poke && en_o;
      valid_c = 1'b0;
      if (en_o) got.push_back(head_o);
      if (en_o && ready_o) ovl = 1;
      if (done_o) break;
      if (cyc > 400) begin tmo = 1; break; end
      if (ready_o && wi < wq.size()) begin
        if (idle > 0) idle--;
        else begin
          valid_c = 1'b1; word_c = wq[wi]; wi++;
          idle = $urandom_range(idle_max, 0);
        end
      end
    end
    start_c = 1'b0; valid_c = 1'b0;
    gv = '0; ev = '0;
    for (int i = 0; i < n; i++) ev[i] = exp_bit(i);
    for (int i = 0; i < got.size() && i < 16; i++) gv[i] = got[i];
    checks++; if (tmo) begin errors++; $display("FAIL %s timeout: done not seen in %0d cycles", name, cyc); end
    checks++; if (got.size() != n) begin errors++; $display("FAIL %s enable count got=%0d exp=%0d", name, got.size(), n); end
    checks++; if (gv !== ev) begin errors++; $display("FAIL %s bits got=%h exp=%h", name, gv, ev); end
    checks++; if ({busy_o, en_o, ready_o} !== 3'b000) begin errors++; $display("FAIL %s end outputs busy/en/ready got=%b exp=000", name, {busy_o, en_o, ready_o}); end
    checks++; if (ovl) begin errors++; $display("FAIL %s prog_clk_en overlapped word_ready got=1 exp=0", name); end
    checks++; if (err_o !== exp_err) begin errors++; $display("FAIL %s err got=%b exp=%b", name, err_o, exp_err); end
    if (idle_max == 0) begin
      checks++;
      if (cyc != wq.size() + n + 1 + first_idle) begin
        errors++; $display("FAIL %s done latency got=%0d exp=%0d", name, cyc, wq.size() + n + 1 + first_idle);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_c = 1'b1;
    @(posedge clk); #1;
    checks++; if ({r4, h4, e4, b4, d4, x4} !== 6'b0) begin errors++; $display("FAIL reset dut4 outs got=%b exp=000000", {r4, h4, e4, b4, d4, x4}); end
    checks++; if ({r10, h10, e10, b10, d10, x10} !== 6'b0) begin errors++; $display("FAIL reset dut10 outs got=%b exp=000000", {r10, h10, e10, b10, d10, x10}); end
    @(negedge clk); start_c = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({b4, r4, b10, r10} !== 4'b0) begin errors++; $display("FAIL reset start-ignored busy/ready got=%b exp=0000", {b4, r4, b10, r10}); end
  endtask

  task automatic test_single_word();
    logic [3:0] g;
    sel = 1'b0; wq.delete(); wq.push_back(8'hA5);
    run_load("single_word", 0, 0, 0, 0);
    g = '0;
    for (int i = 0; i < 4 && i < got.size(); i++) g[3 - i] = got[i];
    checks++; if (g !== 4'b1010) begin errors++; $display("FAIL single_word head seq got=%b exp=1010", g); end
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL single_word done got=%b exp=1", done_o); end
  endtask

  task automatic test_partial_word();
    logic [9:0] g;
    sel = 1'b1; wq.delete(); wq.push_back(8'hF0); wq.push_back(8'hC0);
    run_load("partial_word", 0, 0, 0, 0);
    g = '0;
    for (int i = 0; i < 10 && i < got.size(); i++) g[9 - i] = got[i];
    checks++; if (g !== 10'b1111000011) begin errors++; $display("FAIL partial_word head seq got=%b exp=1111000011", g); end
  endtask

  task automatic test_valid_stall();
    sel = 1'b0; wq.delete(); wq.push_back(8'($urandom));
    run_load("valid_stall", 5, 0, 0, 0);
  endtask

  task automatic test_reset_mid_shift();
    int cnt, guard;
    bit sent;
    sel = 1'b0; cnt = 0; guard = 0; sent = 0;
    @(negedge clk); start_c = 1'b1;
    while (cnt < 2 && guard < 50) begin
      @(negedge clk); guard++;
      start_c = 1'b0; valid_c = 1'b0;
      if (en_o) cnt++;
      if (cnt < 2 && ready_o && !sent) begin valid_c = 1'b1; word_c = 8'($urandom); sent = 1; end
    end
    checks++; if (cnt != 2) begin errors++; $display("FAIL reset_mid bits before reset got=%0d exp=2", cnt); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({ready_o, head_o, en_o, busy_o, done_o, err_o} !== 6'b0) begin
      errors++; $display("FAIL reset_mid async outs got=%b exp=000000", {ready_o, head_o, en_o, busy_o, done_o, err_o});
    end
    valid_c = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    wq.delete(); wq.push_back(8'($urandom));
    run_load("reset_mid_reload", 0, 0, 0, 0);
  endtask

  task automatic test_start_while_busy();
    sel = 1'b1; wq.delete(); wq.push_back(8'($urandom)); wq.push_back(8'($urandom));
    run_load("start_while_busy", 0, 0, 1, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      int im;
      sel = 1'($urandom_range(1, 0));
      wq.delete();
      for (int w = 0; w < (clen() + 7) / 8; w++) wq.push_back(8'($urandom));
      im = $urandom_range(2, 0);
      run_load("random", 0, im, 1'($urandom_range(1, 0)), 0);
    end
  endtask

  task automatic test_crc();
`ifdef CCFF_CRC_EN
    sel = 1'b0; wq.delete(); wq.push_back(8'hA5);
    run_load("crc_bad_trailer", 0, 0, 0, 1);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL crc_bad_trailer err got=%b exp=1", err_o); end
    wq.delete(); wq.push_back(8'hA5);
    run_load("crc_good_trailer", 0, 0, 0, 0);
`else
    checks++; if ({x4, x10} !== 2'b00) begin errors++; $display("FAIL crc_disabled err got=%b exp=00", {x4, x10}); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_partial_word();
    test_valid_stall();
    test_reset_mid_shift();
    test_start_while_busy();
    test_random();
    test_crc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
